// File: rtl/instr_pkg.sv
// instr_pkg: shared encoding definitions for the instruction encoder and the control unit.
//   - OP_*  : 6-bit opcodes placed in word bits [31:26]
//   - MN_*  : 4-bit mnemonic codes accepted on the descriptor interface
//   - fmt_e : word layout selected by a mnemonic
//   - mnem_fmt / mnem_opcode : mnemonic decode helpers
package instr_pkg;

  // Opcodes, shared with the control unit decoder.
  localparam logic [5:0] OP_ADD  = 6'b000000;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ADDU = 6'b000001;
  localparam logic [5:0] OP_SUB  = 6'b000010;
  localparam logic [5:0] OP_SUBU = 6'b000011;
  localparam logic [5:0] OP_SLL  = 6'b000100;
  localparam logic [5:0] OP_SRL  = 6'b000101;
  localparam logic [5:0] OP_NOR  = 6'b000110;
  localparam logic [5:0] OP_AND  = 6'b000111;
  localparam logic [5:0] OP_OR   = 6'b001001;
  localparam logic [5:0] OP_ORI  = 6'b001010;
  localparam logic [5:0] OP_XOR  = 6'b001011;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;

  // Mnemonic codes on the descriptor interface.
  localparam logic [3:0] MN_ADD  = 4'd0;
  localparam logic [3:0] MN_ADDI = 4'd1;
  localparam logic [3:0] MN_ADDU = 4'd2;
  localparam logic [3:0] MN_SUB  = 4'd3;
  localparam logic [3:0] MN_SUBU = 4'd4;
  localparam logic [3:0] MN_SLL  = 4'd5;
  localparam logic [3:0] MN_SRL  = 4'd6;
  localparam logic [3:0] MN_NOR  = 4'd7;
  localparam logic [3:0] MN_AND  = 4'd8;
  localparam logic [3:0] MN_ANDI = 4'd9;   // illegal: its opcode would collide with ADDI
  localparam logic [3:0] MN_OR   = 4'd10;
  localparam logic [3:0] MN_ORI  = 4'd11;
  localparam logic [3:0] MN_XOR  = 4'd12;
  localparam logic [3:0] MN_LW   = 4'd13;
  localparam logic [3:0] MN_SW   = 4'd14;
  localparam logic [3:0] MN_RSVD = 4'd15;  // illegal

  typedef enum logic [1:0] {FMT_R, FMT_S, FMT_I, FMT_BAD} fmt_e;

  function automatic fmt_e mnem_fmt(input logic [3:0] mnem);
    fmt_e fmt;
    case (mnem)
      MN_ADD, MN_ADDU, MN_NOR, MN_AND, MN_OR, MN_XOR:   fmt = FMT_R;
      MN_SLL, MN_SRL:                                   fmt = FMT_S;
      MN_ADDI, MN_SUB, MN_SUBU, MN_ORI, MN_LW, MN_SW:   fmt = FMT_I;
      default:                                          fmt = FMT_BAD;
    endcase
    return fmt;
  endfunction

  function automatic logic [5:0] mnem_opcode(input logic [3:0] mnem);
    logic [5:0] opc;
    case (mnem)
      MN_ADD:  opc = OP_ADD;
      MN_ADDI: opc = OP_ADDI;
      MN_ADDU: opc = OP_ADDU;
      MN_SUB:  opc = OP_SUB;
      MN_SUBU: opc = OP_SUBU;
      MN_SLL:  opc = OP_SLL;
      MN_SRL:  opc = OP_SRL;
      MN_NOR:  opc = OP_NOR;
      MN_AND:  opc = OP_AND;
      MN_OR:   opc = OP_OR;
      MN_ORI:  opc = OP_ORI;
      MN_XOR:  opc = OP_XOR;
      MN_LW:   opc = OP_LW;
      MN_SW:   opc = OP_SW;
      default: opc = 6'b000000;
    endcase
    return opc;
  endfunction

endpackage

// File: rtl/instr_field_packer.sv
// instr_field_packer: combinational packing of one instruction descriptor into a 32-bit word.
// Ports:
//   mnem_i            mnemonic code
//   rs_i, rt_i, rd_i  register fields
//   shamt_i           shift amount
//   imm_i             16-bit immediate
//   word_o            packed instruction word (0 when illegal)
//   illegal_o         mnemonic has no encoding
module instr_field_packer
  import instr_pkg::*;
(
  input  logic [3:0]  mnem_i,
  input  logic [4:0]  rs_i,
  input  logic [4:0]  rt_i,
  input  logic [4:0]  rd_i,
  input  logic [4:0]  shamt_i,
  input  logic [15:0] imm_i,
  output logic [31:0] word_o,
  output logic        illegal_o
);

  fmt_e       fmt;
  logic [5:0] opc;

  always_comb begin
    fmt       = mnem_fmt(mnem_i);
    opc       = mnem_opcode(mnem_i);
    word_o    = 32'h0;
    illegal_o = 1'b0;
    // Fields unused by the selected layout are dropped, never leaked into the word.
    unique case (fmt)
      FMT_R:   word_o = {opc, rs_i, rt_i, rd_i, 11'b0};
      FMT_S:   word_o = {opc, rs_i, 5'b0, rd_i, shamt_i, 6'b0};
      FMT_I:   word_o = {opc, rs_i, rt_i, imm_i};
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// instr_encoder: accepts instruction descriptors over valid/ready, packs each into a 32-bit
// word and writes the words sequentially into instruction memory.
// Ports:
//   clk, reset (sync, active-low)   clock and reset
//   start                           clear write address, enter RUN
//   in_valid / in_ready             descriptor handshake
//   in_mnem, in_rs, in_rt, in_rd,
//   in_shamt, in_imm, in_last       descriptor fields
//   imem_we, imem_addr, imem_wdata  registered memory write port (1-cycle latency)
//   count                           words written since start
//   done, full                      status levels
//   err                             one-cycle pulse on an illegal mnemonic
module instr_encoder
  import instr_pkg::*;
#(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_mnem,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_shamt,
  input  logic [15:0]       in_imm,
  input  logic              in_last,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic [ADDR_W:0]   count,
  output logic              done,
  output logic              full,
  output logic              err
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  // count value equal to DEPTH = 2**ADDR_W
  localparam logic [ADDR_W:0] CountFull = {1'b1, {ADDR_W{1'b0}}};

  logic [1:0]        state_q, state_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              err_q, err_d;

  logic [31:0] word;
  logic        illegal;
  logic        accept;

  instr_field_packer u_packer (
    .mnem_i    (in_mnem),
    .rs_i      (in_rs),
    .rt_i      (in_rt),
    .rd_i      (in_rd),
    .shamt_i   (in_shamt),
    .imm_i     (in_imm),
    .word_o    (word),
    .illegal_o (illegal)
  );

  always_comb begin
    // A beat offered alongside start is never taken.
    in_ready = (state_q == StRun) && !start;
    accept   = in_valid && in_ready;

    state_d = state_q;
    count_d = count_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    err_d   = 1'b0;

    if (start) begin
      state_d = StRun;
      count_d = '0;
    end else if (accept) begin
      if (illegal) begin
        // Illegal beat is consumed but leaves count and memory untouched.
        err_d = 1'b1;
        if (in_last) begin
          state_d = StDone;
        end
      end else begin
        we_d    = 1'b1;
        addr_d  = count_q[ADDR_W-1:0];
        wdata_d = word;
        count_d = count_q + 1'b1;
        // Stop at capacity so the address never wraps.
        if (in_last || (count_d == CountFull)) begin
          state_d = StDone;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= StIdle;
      count_q <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    imem_we    = we_q;
    imem_addr  = addr_q;
    imem_wdata = wdata_q;
    count      = count_q;
    done       = (state_q == StDone);
    full       = (count_q == CountFull);
    err        = err_q;
  end

endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: scoreboard bench for instr_encoder with a small (ADDR_W=2) memory so the
// capacity limit is reachable. A reference model predicts handshake, status and every write;
// a negedge monitor pops and compares.
module tb_instr_encoder;

  localparam int unsigned ADDR_W = 2;
  localparam int unsigned DEPTH  = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              start = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [3:0]        in_mnem = '0;
  logic [4:0]        in_rs = '0;
  logic [4:0]        in_rt = '0;
  logic [4:0]        in_rd = '0;
  logic [4:0]        in_shamt = '0;
  logic [15:0]       in_imm = '0;
  logic              in_last = 1'b0;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic [ADDR_W:0]   count;
  logic              done;
  logic              full;
  logic              err;

  always #5 clk = ~clk;

  instr_encoder #(.ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_mnem    (in_mnem),
    .in_rs      (in_rs),
    .in_rt      (in_rt),
    .in_rd      (in_rd),
    .in_shamt   (in_shamt),
    .in_imm     (in_imm),
    .in_last    (in_last),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .count      (count),
    .done       (done),
    .full       (full),
    .err        (err)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, want, $time);
    end
  endtask

  // Reference tables indexed by mnemonic code; 'X' marks an illegal code.
  int    ref_opc [16] = '{0, 8, 1, 2, 3, 4, 5, 6, 7, 0, 9, 10, 11, 35, 43, 0};
  string ref_fmt = "RIRIISSRRXRIRIIX";

  function automatic logic [31:0] ref_word(input int mn, input int rs, input int rt,
                                           input int rd, input int sh, input int imm);
    longint w;
    byte    f;
    f = ref_fmt[mn];
    w = longint'(ref_opc[mn]) * 67108864 + longint'(rs) * 2097152;
    if (f == "R")      w = w + rt * 65536 + rd * 2048;
    else if (f == "S") w = w + rd * 2048 + sh * 64;
    else               w = w + rt * 65536 + imm;
    return w[31:0];
  endfunction

  typedef struct {
    bit          is_err;
    int unsigned addr;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];

  bit          m_run = 1'b0;
  bit          m_done = 1'b0;
  int unsigned m_count = 0;
  bit          m_accepted = 1'b0;

  // Reference model: advances on each rising edge from the inputs alone.
  always @(posedge clk) begin
    exp_t e;
    m_accepted = 1'b0;
    if (!reset) begin
      m_run   = 1'b0;
      m_done  = 1'b0;
      m_count = 0;
    end else if (start) begin
      m_run   = 1'b1;
      m_done  = 1'b0;
      m_count = 0;
    end else if (m_run && in_valid) begin
      m_accepted = 1'b1;
      if (ref_fmt[in_mnem] == "X") begin
        e = '{is_err: 1'b1, addr: 0, data: 32'h0};
        exp_q.push_back(e);
        if (in_last) begin
          m_run  = 1'b0;
          m_done = 1'b1;
        end
      end else begin
        e = '{is_err: 1'b0, addr: m_count,
              data: ref_word(in_mnem, in_rs, in_rt, in_rd, in_shamt, in_imm)};
        exp_q.push_back(e);
        m_count++;
        if (in_last || m_count == DEPTH) begin
          m_run  = 1'b0;
          m_done = 1'b1;
        end
      end
    end
  end

  // Monitor: status every cycle; each predicted response must appear exactly one cycle later.
  always @(negedge clk) begin
    exp_t e;
    check("in_ready", in_ready, m_run && !start);
    check("done", done, m_done);
    check("full", full, m_count == DEPTH);
    check("count", count, m_count);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("imem_we", imem_we, !e.is_err);
      check("err", err, e.is_err);
      if (!e.is_err) begin
        check("imem_addr", imem_addr, e.addr);
        check("imem_wdata", imem_wdata, e.data);
      end
    end else begin
      check("imem_we idle", imem_we, 1'b0);
      check("err idle", err, 1'b0);
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    idle(1);
    start = 1'b0;
  endtask

  // Present a beat and hold it until the model says it was taken.
  task automatic send(input logic [3:0] mn, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] rd, input logic [4:0] sh, input logic [15:0] imm,
                      input bit last);
    bit taken;
    taken    = 1'b0;
    in_mnem  = mn;
    in_rs    = rs;
    in_rt    = rt;
    in_rd    = rd;
    in_shamt = sh;
    in_imm   = imm;
    in_last  = last;
    in_valid = 1'b1;
    for (int i = 0; i < 40 && !taken; i++) begin
      idle(1);
      taken = m_accepted;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (!taken) begin
      checks++;
      errors++;
      $display("FAIL send timeout: beat mnem=%0d not accepted, expected acceptance", mn);
    end
  endtask

  task automatic send_rand(input bit last);
    send(4'($urandom_range(0, 15)), 5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
         16'($urandom), last);
  endtask

  initial begin
    // Reset state
    reset = 1'b0;
    idle(2);
    reset = 1'b1;
    check("rst in_ready", in_ready, 0);
    check("rst imem_we", imem_we, 0);
    check("rst imem_addr", imem_addr, 0);
    check("rst imem_wdata", imem_wdata, 0);
    check("rst count", count, 0);
    check("rst done", done, 0);
    check("rst full", full, 0);
    check("rst err", err, 0);

    // ADD rs=1 rt=2 rd=3
    pulse_start();
    send(4'd0, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 1'b0);
    check("ADD word", imem_wdata, 32'h00221800);
    check("ADD addr", imem_addr, 0);
    check("ADD count", count, 1);

    // LW then SLL back-to-back
    pulse_start();
    send(4'd13, 5'd29, 5'd8, 5'd0, 5'd0, 16'h0004, 1'b0);
    check("LW word", imem_wdata, 32'h8FA80004);
    check("LW addr", imem_addr, 0);
    send(4'd5, 5'd4, 5'd0, 5'd5, 5'd2, 16'h0, 1'b0);
    check("SLL word", imem_wdata, 32'h10802880);
    check("SLL addr", imem_addr, 1);
    check("SLL we", imem_we, 1);

    // ANDI is illegal; next legal write reuses the address
    send(4'd9, 5'd1, 5'd1, 5'd1, 5'd0, 16'h1234, 1'b0);
    check("ANDI err", err, 1);
    check("ANDI we", imem_we, 0);
    check("ANDI count", count, 2);
    idle(1);
    check("err one cycle", err, 0);
    send(4'd12, 5'd7, 5'd6, 5'd5, 5'd0, 16'h0, 1'b0);
    check("after ANDI addr", imem_addr, 2);

    // Capacity: four writes then a held fifth beat
    pulse_start();
    for (int i = 0; i < 4; i++) send(4'd2, 5'(i), 5'(i + 1), 5'(i + 2), 5'd0, 16'h0, 1'b0);
    check("cap full", full, 1);
    check("cap done", done, 1);
    check("cap in_ready", in_ready, 0);
    check("cap addr", imem_addr, 3);
    in_valid = 1'b1;
    idle(5);
    in_valid = 1'b0;
    check("cap held count", count, 4);

    // in_last on the third beat, then restart
    pulse_start();
    send(4'd10, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 1'b0);
    send(4'd11, 5'd1, 5'd2, 5'd0, 5'd0, 16'hBEEF, 1'b0);
    send(4'd14, 5'd3, 5'd4, 5'd0, 5'd0, 16'h0010, 1'b1);
    check("last done", done, 1);
    check("last in_ready", in_ready, 0);
    check("last full", full, 0);
    pulse_start();
    check("restart count", count, 0);
    send(4'd7, 5'd9, 5'd10, 5'd11, 5'd0, 16'h0, 1'b0);
    check("restart addr", imem_addr, 0);

    // start in the cycle after an accept
    send(4'd6, 5'd2, 5'd0, 5'd3, 5'd31, 16'h0, 1'b0);
    pulse_start();
    check("start after accept count", count, 0);

    // Reset in the cycle after an accept, with another beat offered
    send(4'd3, 5'd1, 5'd2, 5'd0, 5'd0, 16'h00FF, 1'b0);
    reset    = 1'b0;
    in_valid = 1'b1;
    idle(1);
    in_valid = 1'b0;
    check("mid rst imem_we", imem_we, 0);
    check("mid rst imem_addr", imem_addr, 0);
    check("mid rst imem_wdata", imem_wdata, 0);
    check("mid rst count", count, 0);
    check("mid rst in_ready", in_ready, 0);
    reset = 1'b1;
    idle(2);

    // Randomized programs, with occasional mid-program restarts
    for (int p = 0; p < 60; p++) begin
      int len;
      pulse_start();
      len = $urandom_range(1, 6);
      for (int k = 0; k < len && m_run; k++) begin
        send_rand(k == len - 1);
        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
        if ($urandom_range(0, 9) == 0) pulse_start();
      end
      idle($urandom_range(0, 2));
    end

    idle(3);
    check("scoreboard drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Instruction encoder/loader for the single-cycle CPU. It accepts decoded instruction descriptions (mnemonic plus register and immediate fields) over a valid/ready handshake and packs each into the 32-bit word format that the control unit decodes. It then writes the words sequentially into instruction memory. The bench and boot logic use it to build programs without hand-assembling hex.

## Interface
- ADDR_W, 8: instruction memory address width. Capacity is DEPTH = 2**ADDR_W words.
- clk  input  1  system clock. All state updates on the rising edge.
- reset  input  1  one clock; reset is synchronous and active-low.
- start  input  1  single-cycle pulse. Clears the write address and enters RUN.
- in_valid  input  1  descriptor valid.
- in_ready  output  1  descriptor accepted when in_valid and in_ready are both high.
- in_mnem  input  4  mnemonic code (see Operation).
- in_rs, in_rt, in_rd, in_shamt  input  5 each  register and shift fields.
- in_imm  input  16  immediate field.
- in_last  input  1  marks the final descriptor of the program.
- imem_we  output  1  instruction-memory write strobe, one cycle per word.
- imem_addr  output  ADDR_W  write address.
- imem_wdata  output  32  encoded instruction.
- count  output  ADDR_W+1  number of words written since start.
- done  output  1  level signal. High in the DONE state.
- full  output  1  level signal. High when count == DEPTH.
- err  output  1  one-cycle pulse on an illegal mnemonic.

## Operation
- Mnemonic codes and their opcodes:
  - 0 ADD 000000, 1 ADDI 001000, 2 ADDU 000001, 3 SUB 000010, 4 SUBU 000011
  - 5 SLL 000100, 6 SRL 000101, 7 NOR 000110, 8 AND 000111
  - 10 OR 001001, 11 ORI 001010, 12 XOR 001011, 13 LW 100011, 14 SW 101011
- Codes 9 (ANDI) and 15 are illegal. ANDI is illegal because its opcode collides with ADDI.
- Word formats. Bits [31:26] always hold the opcode.
  - R-form (ADD, ADDU, NOR, AND, OR, XOR): [25:21]=rs, [20:16]=rt, [15:11]=rd, [10:0]=0.
  - S-form (SLL, SRL): [25:21]=rs, [20:16]=0, [15:11]=rd, [10:6]=shamt, [5:0]=0.
  - I-form (ADDI, SUB, SUBU, ORI, LW, SW): [25:21]=rs, [20:16]=rt, [15:0]=imm.
- Fields the selected format does not use are ignored.
- States:
  - IDLE (after reset): start moves to RUN.
  - RUN: accepts descriptors. Moves to DONE after accepting an in_last beat, or after the accept that makes count reach DEPTH.
  - DONE: start moves back to RUN.
- start in any state clears count to 0 and enters RUN.
- in_ready = (state == RUN) && !start. A beat presented in the start cycle is not accepted.
- Legal accepted beat: the word is registered and written at imem_addr = count[ADDR_W-1:0]; count then increments.
- Illegal accepted beat:
  - consumed, err pulses, nothing is written, count is unchanged;
  - if in_last is set, the block still moves to DONE.
- Reset values: state IDLE, count 0. in_ready, imem_we, imem_addr, imem_wdata, done, full and err are all 0.

## Timing
- Latency is 1 cycle. An accept at edge N gives imem_we, imem_addr and imem_wdata valid for the cycle after edge N. err follows the same timing.
- Writes can be back-to-back: one word per cycle while in_valid is held high.
- done is high from the cycle after the last accept.
- full rises together with the write strobe of word DEPTH-1. in_ready is low from that same cycle.
- No address wrap: writes stop at DEPTH words. Further beats stall because in_ready is low.
- Reset mid-operation:
  - a pending write strobe is dropped;
  - imem_we is 0 in the cycle after reset is sampled low;
  - memory contents are not cleared.
- start in the cycle after an accept: the pending write still completes at the old address, then count is 0.

## Structure
- Package instr_pkg holds:
  - the opcode localparams (shared with the control unit);
  - the mnemonic codes;
  - a format enum {FMT_R, FMT_S, FMT_I, FMT_BAD}.
- Sub-module instr_field_packer: combinational. Takes mnemonic and fields; produces the 32-bit word and an illegal flag.
- Top level holds the FSM, count, output registers and handshake.

## Test plan
- start, then ADD rs=1 rt=2 rd=3 -> imem_wdata 0x00221800 at addr 0, one cycle later; count=1.
- LW rs=29 rt=8 imm=0x0004, then SLL rs=4 rd=5 shamt=2 back-to-back -> 0x8FA80004 at addr 0 and 0x10802880 at addr 1, on consecutive cycles.
- ANDI descriptor -> err pulses for 1 cycle, no imem_we, count unchanged. The next legal beat writes to the same address.
- ADDR_W=2, five beats with in_valid held high:
  - four writes to addrs 0–3;
  - full=1 and done=1;
  - in_ready=0, and the fifth beat is held unaccepted.
- in_last on the 3rd beat -> done=1, in_ready=0. A later start gives count=0 and the next write goes to addr 0.
- reset low in the cycle after an accept -> no write strobe, all outputs 0, state IDLE.
